nn_ctrl_seq: RTL and testbench
==============================

# nn_ctrl_seq

Sequential, parametrised control unit for the NN CPU datapath. It decodes the 4-bit ISA (NOP, ADD, ADDI, MUL, SINN, MAC, LD, ST, HALT) into registered datapath controls and sequences the multi-cycle operations:

- MAC waits a fixed ALU latency.
- LD/ST wait on a memory-ready handshake.
- HALT and illegal opcodes park the core in a flag-reporting state instead of ending simulation.

It sits between instruction fetch (PC/instruction memory) and the datapath (register file, ALU1/ALU2, data memory).

## Interface
- OPW, 4 — opcode width. Must be ≥4. Any set bit above bit 3 makes the opcode illegal.
- ALUCW, 3 — ALU control width. Idle/pass code is all-ones.
- MAC_LAT, 2 — MAC latency in cycles, ≥1.
- CNTW, 16 — width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch presents a valid opcode
- opcode  in  OPW  instruction opcode
- mem_ready  in  1  data memory completes current LD/ST this cycle
- instr_ready  out  1  unit can accept an opcode (state RUN)
- pc_en  out  1  PC advance; equals accept = instr_valid & instr_ready (combinational)
- reg_write  out  1  register-file write strobe, commit cycle only
- mem_to_reg  out  1  1 = ALU2 result to writeback, 0 = memory data
- mem_write  out  1  data-memory write request (ST)
- mem_req  out  1  data-memory access request (LD or ST)
- alu_ctl1  out  ALUCW  ALU1 op
- alu_ctl2  out  ALUCW  ALU2 op
- alu_src  out  1  1 = immediate operand
- reg_dst  out  1  1 = Rd (R-type), 0 = Rt
- halted  out  1  sticky, HALT executed
- illegal_op  out  1  sticky, undefined opcode accepted
- retired  out  CNTW  count of committed instructions, wraps

## Operation
- Decode fields per opcode, listed as alu_ctl1/alu_ctl2/alu_src/reg_dst/mem_to_reg/write:
  - NOP 0000: 111/111/0/0/1/none
  - ADD 0001: 000/111/0/1/1/reg
  - ADDI 1001: 000/111/1/0/1/reg
  - MUL 0010: 001/111/0/1/1/reg
  - SINN 0011: 010/111/0/1/1/reg
  - MAC 0100: 001/000/0/1/1/reg
  - LD 1110: 000/111/1/0/0/reg
  - ST 1111: 000/111/1/0/0/mem
  - HALT 1011
  - all others illegal.
- States: RUN, MAC_WAIT, MEM_WAIT, HALTED, ERROR.
- RUN, on accept:
  - Decode fields are registered.
  - Single-cycle ops stay in RUN.
  - MAC with MAC_LAT>1 → MAC_WAIT, counter loaded with MAC_LAT-1.
  - LD/ST → MEM_WAIT.
  - HALT → HALTED.
  - Illegal → ERROR.
  - No accept: fields return to NOP values and strobes go to 0.
- MAC_WAIT: fields held. Counter decrements each cycle. At 0, reg_write pulses for one cycle and the state returns to RUN.
- MEM_WAIT:
  - mem_req=1, held from the cycle after accept through the cycle where mem_ready=1 (inclusive).
  - ST: mem_write=1 over the same span.
  - LD: reg_write=1 only in the mem_ready cycle.
  - The state returns to RUN after the mem_ready cycle.
- HALTED and ERROR: terminal until reset. Fields are NOP values, instr_ready=0, halted/illegal_op=1 respectively.
- retired increments by 1 in each commit cycle. Commit cycles are:
  - the decode cycle of NOP/ADD/ADDI/MUL/SINN;
  - the reg_write cycle of MAC;
  - the mem_ready cycle of LD/ST;
  - the HALT decode cycle.
- Illegal opcodes do not count. The counter wraps from 2^CNTW-1 to 0.

## Timing
- Reset (asynchronous, immediate):
  - state RUN;
  - reg_write, mem_write, mem_req, alu_src, reg_dst, halted, illegal_op = 0;
  - mem_to_reg=1; alu_ctl1/alu_ctl2 all-ones; retired=0.
  - instr_ready=1 after reset deasserts.
- Single-cycle op accepted at cycle t: controls and reg_write valid at t+1. Back-to-back accepts are allowed (throughput 1/cycle).
- MAC accepted at t: reg_write asserted at t+MAC_LAT only. instr_ready=0 for cycles t+1 .. t+MAC_LAT. Next accept no earlier than t+MAC_LAT+1.
- LD/ST accepted at t: mem_req from t+1. If mem_ready is already high at t+1, the op commits at t+1. mem_ready is ignored outside MEM_WAIT.
- pc_en is combinational and never asserted when instr_ready=0.
- Reset during MAC_WAIT or MEM_WAIT aborts the operation: no commit, and strobes drop immediately.

## Structure
- Package nn_ctrl_pkg holds:
  - opcode localparams;
  - ALU codes (ADD 000, MUL 001, SLT 010, PASS all-ones);
  - the state enum;
  - a packed ctrl_t struct (alu_ctl1, alu_ctl2, alu_src, reg_dst, mem_to_reg, wr_reg, wr_mem, legal, is_mac, is_mem, is_halt).
- Sub-module nn_ctrl_decode: purely combinational opcode → ctrl_t. The top holds the FSM, the MAC counter, the registered fields and the retired counter.

## Test plan
- Reset, then ADD, ADDI, MUL, SINN on consecutive cycles:
  - each output set (e.g. ADDI: alu_src=1, reg_dst=0, alu_ctl1=000) appears one cycle after its accept;
  - reg_write pulses 4 times; retired=4.
- MAC with MAC_LAT=3, accepted at t:
  - alu_ctl1=001, alu_ctl2=000 held;
  - reg_write only at t+3; instr_ready low for t+1..t+3.
- ST with mem_ready delayed 4 cycles:
  - mem_req and mem_write high for 5 cycles;
  - reg_write never asserted;
  - LD with mem_ready at t+1 commits at t+1 with mem_to_reg=0.
- HALT then further instr_valid: halted=1, pc_en=0, retired unchanged thereafter. Opcode 0101 → illegal_op=1, retired not incremented.
- Assert rst_n low mid-MEM_WAIT: mem_req drops in the same cycle and state returns to RUN. Preload retired=0xFFFF and commit a NOP: retired wraps to 0.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types for the NN CPU control unit.
// Opcodes, ALU op codes, FSM states and decode bundles.
package nn_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_SINN = 4'b0011;
  localparam logic [3:0] OP_MAC  = 4'b0100;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ST   = 4'b1111;
  localparam logic [3:0] OP_HALT = 4'b1011;

  // PASS widens to all-ones at the port, whatever ALUCW is.
  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_MUL  = 2'b01,
    ALU_SLT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_MAC_WAIT,
    ST_MEM_WAIT,
    ST_HALTED,
    ST_ERROR
  } state_e;

  typedef struct packed {
    alu_op_e alu_ctl1;
    alu_op_e alu_ctl2;
    logic    alu_src;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    wr_reg;
    logic    wr_mem;
    logic    legal;
    logic    is_mac;
    logic    is_mem;
    logic    is_halt;
  } ctrl_t;

  typedef struct packed {
    alu_op_e alu_ctl1;
    alu_op_e alu_ctl2;
    logic    alu_src;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    wr_reg;
    logic    wr_mem;
  } dp_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_ctl1:   ALU_PASS,
    alu_ctl2:   ALU_PASS,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    mem_to_reg: 1'b1,
    wr_reg:     1'b0,
    wr_mem:     1'b0,
    legal:      1'b1,
    is_mac:     1'b0,
    is_mem:     1'b0,
    is_halt:    1'b0
  };

  localparam dp_t DP_NOP = '{
    alu_ctl1:   ALU_PASS,
    alu_ctl2:   ALU_PASS,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    mem_to_reg: 1'b1,
    wr_reg:     1'b0,
    wr_mem:     1'b0
  };

  function automatic dp_t dp_of(input ctrl_t c);
    dp_t d;
    d.alu_ctl1   = c.alu_ctl1;
    d.alu_ctl2   = c.alu_ctl2;
    d.alu_src    = c.alu_src;
    d.reg_dst    = c.reg_dst;
    d.mem_to_reg = c.mem_to_reg;
    d.wr_reg     = c.wr_reg;
    d.wr_mem     = c.wr_mem;
    return d;
  endfunction

endpackage

// File: rtl/nn_ctrl_decode.sv
// Combinational opcode decoder for the NN CPU.
// Any set bit above bit 3 marks the opcode illegal.
module nn_ctrl_decode
  import nn_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode_i,
  output ctrl_t          ctrl_o
);

  logic       hi;
  logic [3:0] op;

  assign op = opcode_i[3:0];

  if (OPW > 4) begin : g_hi
    assign hi = |opcode_i[OPW-1:4];
  end else begin : g_nohi
    assign hi = 1'b0;
  end

  always_comb begin
    ctrl_o = CTRL_NOP;
    unique case (op)
      OP_NOP: ;
      OP_ADD: begin
        ctrl_o.alu_ctl1 = ALU_ADD;
        ctrl_o.reg_dst  = 1'b1;
        ctrl_o.wr_reg   = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_ctl1 = ALU_ADD;
        ctrl_o.alu_src  = 1'b1;
        ctrl_o.wr_reg   = 1'b1;
      end
      OP_MUL: begin
        ctrl_o.alu_ctl1 = ALU_MUL;
        ctrl_o.reg_dst  = 1'b1;
        ctrl_o.wr_reg   = 1'b1;
      end
      OP_SINN: begin
        ctrl_o.alu_ctl1 = ALU_SLT;
        ctrl_o.reg_dst  = 1'b1;
        ctrl_o.wr_reg   = 1'b1;
      end
      OP_MAC: begin
        ctrl_o.alu_ctl1 = ALU_MUL;
        ctrl_o.alu_ctl2 = ALU_ADD;
        ctrl_o.reg_dst  = 1'b1;
        ctrl_o.wr_reg   = 1'b1;
        ctrl_o.is_mac   = 1'b1;
      end
      OP_LD: begin
        ctrl_o.alu_ctl1   = ALU_ADD;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.wr_reg     = 1'b1;
        ctrl_o.is_mem     = 1'b1;
      end
      OP_ST: begin
        ctrl_o.alu_ctl1   = ALU_ADD;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.wr_mem     = 1'b1;
        ctrl_o.is_mem     = 1'b1;
      end
      OP_HALT: ctrl_o.is_halt = 1'b1;
      default: ctrl_o.legal = 1'b0;
    endcase
    if (hi) begin
      ctrl_o       = CTRL_NOP;
      ctrl_o.legal = 1'b0;
    end
  end

endmodule

// File: rtl/nn_ctrl_seq.sv
// NN CPU control sequencer: registered decode,
// MAC latency wait, memory handshake and retire count.
module nn_ctrl_seq
  import nn_ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int ALUCW   = 3,
  parameter int MAC_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             instr_ready,
  output logic             pc_en,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             mem_req,
  output logic [ALUCW-1:0] alu_ctl1,
  output logic [ALUCW-1:0] alu_ctl2,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNTW-1:0]  retired
);

  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MAC_LAT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  dp_t             dp_q, dp_d;
  logic            cm_q, cm_d;
  logic [CNTW-1:0] ret_q;
  ctrl_t           dec;
  logic            accept, mac_done, mem_done, commit;

  nn_ctrl_decode #(.OPW(OPW)) u_dec (
    .opcode_i (opcode),
    .ctrl_o   (dec)
  );

  assign instr_ready = (state_q == ST_RUN);
  assign accept      = instr_valid & instr_ready;
  assign pc_en       = accept;
  assign mac_done    = (state_q == ST_MAC_WAIT) && (cnt_q == '0);
  assign mem_done    = (state_q == ST_MEM_WAIT) && mem_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_d    = DP_NOP;
    cm_d    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          dp_d = dp_of(dec);
          unique case (1'b1)
            !dec.legal: state_d = ST_ERROR;
            dec.is_halt: begin
              state_d = ST_HALTED;
              cm_d    = 1'b1;
            end
            dec.is_mem: state_d = ST_MEM_WAIT;
            dec.is_mac && (MAC_LAT > 1): begin
              state_d = ST_MAC_WAIT;
              cnt_d   = CNT_LOAD;
            end
            default: cm_d = 1'b1;
          endcase
        end
      end
      ST_MAC_WAIT: begin
        if (mac_done) begin
          state_d = ST_RUN;
        end else begin
          dp_d  = dp_q;
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_done) state_d = ST_RUN;
        else          dp_d    = dp_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      dp_q    <= DP_NOP;
      cm_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      cm_q    <= cm_d;
      if (commit) ret_q <= ret_q + 1'b1;
    end
  end

  // Multi-cycle strobes come from live state so reset kills them at once.
  assign commit    = cm_q | mac_done | mem_done;
  assign reg_write = (cm_q & dp_q.wr_reg) | mac_done
                   | (mem_done & dp_q.wr_reg);
  assign mem_req   = (state_q == ST_MEM_WAIT);
  assign mem_write = mem_req & dp_q.wr_mem;

  assign mem_to_reg = dp_q.mem_to_reg;
  assign alu_src    = dp_q.alu_src;
  assign reg_dst    = dp_q.reg_dst;
  assign alu_ctl1   = (dp_q.alu_ctl1 == ALU_PASS) ? '1
                    : ALUCW'(dp_q.alu_ctl1);
  assign alu_ctl2   = (dp_q.alu_ctl2 == ALU_PASS) ? '1
                    : ALUCW'(dp_q.alu_ctl2);
  assign halted     = (state_q == ST_HALTED);
  assign illegal_op = (state_q == ST_ERROR);
  assign retired    = ret_q;

endmodule

// File: tb/tb_nn_ctrl_seq.sv
// Scoreboard bench for nn_ctrl_seq: a per-instruction
// reference model predicts every cycle's outputs.
module tb_nn_ctrl_seq;

  localparam int MAC_LAT = 3;
  localparam int CNTW    = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic [3:0]      opcode = 4'h0;
  logic            mem_ready = 1'b0;
  logic            instr_ready, pc_en, reg_write, mem_to_reg;
  logic            mem_write, mem_req, alu_src, reg_dst;
  logic            halted, illegal_op;
  logic [2:0]      alu_ctl1, alu_ctl2;
  logic [CNTW-1:0] retired;

  nn_ctrl_seq #(
    .OPW(4), .ALUCW(3), .MAC_LAT(MAC_LAT), .CNTW(CNTW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .instr_ready (instr_ready),
    .pc_en       (pc_en),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .mem_write   (mem_write),
    .mem_req     (mem_req),
    .alu_ctl1    (alu_ctl1),
    .alu_ctl2    (alu_ctl2),
    .alu_src     (alu_src),
    .reg_dst     (reg_dst),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy, pce, rw, mreq, mwr, mtr;
    logic [2:0] a1, a2;
    logic       src, dst, hlt, ill, mrdy, cmt;
    logic [7:0] ret;
  } exp_t;

  exp_t       sbq[$];
  exp_t       fut[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         mode_m = 0;
  logic [7:0] ret_m = 8'd0;
  logic [3:0] ops [8] = '{4'h0, 4'h1, 4'h9, 4'h2,
                          4'h3, 4'h4, 4'he, 4'hf};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t nop_rec();
    exp_t r;
    r     = '0;
    r.a1  = 3'b111;
    r.a2  = 3'b111;
    r.mtr = 1'b1;
    return r;
  endfunction

  function automatic exp_t idle_rec();
    exp_t r;
    r     = nop_rec();
    r.rdy = (mode_m == 0);
    r.hlt = (mode_m == 1);
    r.ill = (mode_m == 2);
    return r;
  endfunction

  function automatic exp_t op_rec(input logic [3:0] op);
    exp_t r;
    r = nop_rec();
    case (op)
      4'h1: begin r.a1 = 3'b000; r.dst = 1'b1; end
      4'h9: begin r.a1 = 3'b000; r.src = 1'b1; end
      4'h2: begin r.a1 = 3'b001; r.dst = 1'b1; end
      4'h3: begin r.a1 = 3'b010; r.dst = 1'b1; end
      4'h4: begin
        r.a1 = 3'b001; r.a2 = 3'b000; r.dst = 1'b1;
      end
      4'he, 4'hf: begin
        r.a1 = 3'b000; r.src = 1'b1; r.mtr = 1'b0;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic expand(input logic [3:0] op, input int dly);
    exp_t f, g;
    f = op_rec(op);
    case (op)
      4'h0, 4'h1, 4'h9, 4'h2, 4'h3: begin
        f.rdy = 1'b1;
        f.rw  = (op != 4'h0);
        f.cmt = 1'b1;
        fut.push_back(f);
      end
      4'h4: begin
        for (int i = 0; i < MAC_LAT; i++) begin
          g     = f;
          g.rw  = (i == MAC_LAT - 1);
          g.cmt = (i == MAC_LAT - 1);
          fut.push_back(g);
        end
      end
      4'he, 4'hf: begin
        for (int i = 0; i <= dly; i++) begin
          g      = f;
          g.mreq = 1'b1;
          g.mwr  = (op == 4'hf);
          g.mrdy = (i == dly);
          g.cmt  = (i == dly);
          g.rw   = (i == dly) && (op == 4'he);
          fut.push_back(g);
        end
      end
      4'hb: begin
        mode_m = 1;
        g      = idle_rec();
        g.cmt  = 1'b1;
        fut.push_back(g);
      end
      default: begin
        mode_m = 2;
        fut.push_back(idle_rec());
      end
    endcase
  endtask

  task automatic cycle(input logic v, input logic [3:0] op,
                       input int dly);
    exp_t r;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = (fut.size() > 0) ? fut.pop_front() : idle_rec();
    r.ret = ret_m;
    if (r.cmt) ret_m = ret_m + 8'd1;
    instr_valid = v;
    opcode      = op;
    mem_ready   = r.mreq ? r.mrdy : 1'($urandom_range(0, 1));
    r.pce = v & r.rdy;
    sbq.push_back(r);
    if (r.pce) expand(op, dly);
  endtask

  task automatic rst_cycle();
    exp_t r;
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    fut.delete();
    mode_m = 0;
    ret_m  = 8'd0;
    r      = idle_rec();
    r.ret  = 8'd0;
    sbq.push_back(r);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] act, want;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e    = sbq.pop_front();
        act  = {instr_ready, pc_en, reg_write, mem_req,
                mem_write, mem_to_reg, alu_ctl1, alu_ctl2,
                alu_src, reg_dst, halted, illegal_op};
        want = {e.rdy, e.pce, e.rw, e.mreq, e.mwr, e.mtr,
                e.a1, e.a2, e.src, e.dst, e.hlt, e.ill};
        n_cmp++;
        if (act !== want) begin
          n_bad++;
          $display("FAIL ctl cyc=%0d got=%b want=%b",
                   cyc, act, want);
        end
        n_cmp++;
        if (retired !== e.ret) begin
          n_bad++;
          $display("FAIL retired cyc=%0d got=%0d want=%0d",
                   cyc, retired, e.ret);
        end
      end
    end
  end

  initial begin : driver
    rst_cycle();
    rst_cycle();
    cycle(1, 4'h1, 0);
    cycle(1, 4'h9, 0);
    cycle(1, 4'h2, 0);
    cycle(1, 4'h3, 0);
    repeat (2) cycle(0, 4'h0, 0);
    cycle(1, 4'h4, 0);
    repeat (3) cycle(1, 4'h1, 0);
    cycle(0, 4'h0, 0);
    cycle(1, 4'hf, 4);
    repeat (6) cycle(0, 4'h0, 0);
    cycle(1, 4'he, 0);
    repeat (2) cycle(0, 4'h0, 0);
    repeat (900)
      cycle(1'($urandom_range(0, 9) < 7),
            ops[$urandom_range(0, 7)],
            int'($urandom_range(0, 4)));
    repeat (260) cycle(1, 4'h0, 0);
    cycle(1, 4'hf, 10);
    repeat (3) cycle(0, 4'h0, 0);
    rst_cycle();
    repeat (2) cycle(0, 4'h0, 0);
    cycle(1, 4'h1, 0);
    cycle(1, 4'hb, 0);
    repeat (4) cycle(1, 4'h1, 0);
    rst_cycle();
    cycle(1, 4'h5, 0);
    repeat (4) cycle(1, 4'h1, 0);
    rst_cycle();
    cycle(0, 4'h0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
